// File: rtl/pend_rr_encoder_pkg.sv
// Shared types and helpers for the pending-request round-robin encoder.
package pend_enc_pkg;

    typedef enum logic {IDLE, OFFER} pe_state_t;

    localparam int PE_N_DEFAULT = 8;

    // Bit b of the constant v; used to build encoder columns at elaboration.
    function automatic logic idx_bit(input int unsigned v, input int unsigned b);
        return ((v >> b) & 1) != 0;
    endfunction

endpackage

// File: rtl/pend_rr_encoder_if.sv
// Index offer channel: producer drives index/valid, consumer drives ready.
interface pend_rr_encoder_if import pend_enc_pkg::*; #(
    parameter int N = PE_N_DEFAULT
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             idx_ready;

    modport master (output idx_out, output idx_valid, input idx_ready);
    modport slave  (input idx_out, input idx_valid, output idx_ready);

endinterface

// File: rtl/pend_rr_encoder_rr_pick.sv
// Combinational round-robin picker: first set bit of vec at or after ptr, wrapping.
module rr_pick import pend_enc_pkg::*; #(
    parameter int N = PE_N_DEFAULT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0]   dbl_shift;
    logic [N-1:0]     rot;
    logic [N-1:0]     oh;
    logic [IDX_W-1:0] enc;

    // Rotating right by ptr puts the search start at bit 0.
    assign dbl_shift = {vec, vec} >> ptr;
    assign rot       = dbl_shift[N-1:0];
    assign oh        = rot & (~rot + N'(1));

    genvar gi, gb;
    generate
        for (gb = 0; gb < IDX_W; gb++) begin : g_enc
            logic [N-1:0] col;
            for (gi = 0; gi < N; gi++) begin : g_col
                assign col[gi] = oh[gi] & idx_bit(gi, gb);
            end
            assign enc[gb] = |col;
        end
    endgenerate

    assign found = |vec;
    assign idx   = enc + ptr;

endmodule

// File: rtl/pend_rr_encoder.sv
// Captures request events into sticky pending bits and offers one enabled
// pending index at a time, round-robin, over a valid/ready channel.
module pend_rr_encoder import pend_enc_pkg::*; #(
    parameter int N    = PE_N_DEFAULT,
    parameter bit EDGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_in,
    input  logic [N-1:0]      mask,
    input  logic              clr_all,
    pend_rr_encoder_if.master idx_if,
    output logic [N-1:0]      pending,
    output logic              overflow
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req_d_reg;
    logic             armed_reg;
    logic [N-1:0]     pending_reg, pending_next;
    logic             overflow_reg, overflow_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             valid_reg, valid_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    pe_state_t        state_reg, state_next;

    logic [N-1:0]     evt;
    logic [N-1:0]     acc_mask;
    logic [N-1:0]     cand;
    logic             accept;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // Lines already high when reset releases are not treated as fresh edges.
    assign evt    = EDGE ? (req_in & ~req_d_reg & {N{armed_reg}}) : req_in;
    assign accept = valid_reg & idx_if.idx_ready;
    assign cand   = pending_reg & mask;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_acc
            assign acc_mask[gi] = accept && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    rr_pick #(.N(N)) u_pick (
        .vec   (cand),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // An event on the bit being accepted this cycle re-arms it.
    always_comb begin
        pending_next  = clr_all ? '0 : ((pending_reg & ~acc_mask) | evt);
        overflow_next = EDGE && !clr_all && (|(evt & pending_reg & ~acc_mask));
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                // No new offer from bits that clr_all is wiping this cycle.
                if (!clr_all && pick_found) begin
                    idx_next   = pick_idx;
                    valid_next = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    ptr_next = idx_reg + IDX_W'(1);
                end
                if (accept || clr_all) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_reg    <= '0;
            armed_reg    <= 1'b0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            ptr_reg      <= '0;
            state_reg    <= IDLE;
        end else begin
            req_d_reg    <= req_in;
            armed_reg    <= 1'b1;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            idx_reg      <= idx_next;
            valid_reg    <= valid_next;
            ptr_reg      <= ptr_next;
            state_reg    <= state_next;
        end
    end

    assign idx_if.idx_out   = idx_reg;
    assign idx_if.idx_valid = valid_reg;
    assign pending          = pending_reg;
    assign overflow         = overflow_reg;

endmodule
